// File: rtl/mem_access.sv
// Memory-access stage: passes ALU results through to write-back and runs word loads/stores as req/ack bus transactions.
// Optional macro MEM_MISALIGN_CHK_EN turns misaligned accesses into a MEM_misalign pulse instead of a bus request.
module mem_access (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EX_x_rd_vld,
    input  logic [31:0] EX_x_rd,
    input  logic [4:0]  EX_rd_idx,
    input  logic [31:0] EX_MEMaddr,
    input  logic [3:0]  EX_MEMrden,
    input  logic [3:0]  EX_MEMwren,
    input  logic [31:0] EX_MEMwrdata,
    output logic        MEM_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        MEM_x_rd_vld,
    output logic [31:0] MEM_x_rd,
    output logic [4:0]  MEM_rd_idx,
    output logic        MEM_misalign
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_is_read;
    logic        w_mem_op;
    logic        w_misaligned;
    logic        w_accept;
    logic        r_dmem_req;
    logic        r_dmem_we;
    logic [31:0] r_dmem_addr;
    logic [3:0]  r_dmem_be;
    logic [31:0] r_dmem_wdata;
    logic [4:0]  r_ld_idx;
    logic        r_mem_x_rd_vld;
    logic [31:0] r_mem_x_rd;
    logic [4:0]  r_mem_rd_idx;

    assign w_is_read = |EX_MEMrden;
    assign w_mem_op  = w_is_read || (|EX_MEMwren);

`ifdef MEM_MISALIGN_CHK_EN
    logic r_misalign;
    assign w_misaligned = (EX_MEMaddr[1:0] != 2'b00);
    assign MEM_misalign = r_misalign;
`else
    assign w_misaligned = 1'b0;
    assign MEM_misalign = 1'b0;
`endif

    assign w_accept = (r_state == ST_IDLE) && w_mem_op && !w_misaligned;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        MEM_stall    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_WAIT;
                    MEM_stall    = 1'b1;
                end
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    w_state_next = ST_IDLE;
                end else begin
                    MEM_stall = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dmem_req     <= 1'b0;
            r_dmem_we      <= 1'b0;
            r_dmem_addr    <= 32'd0;
            r_dmem_be      <= 4'd0;
            r_dmem_wdata   <= 32'd0;
            r_ld_idx       <= 5'd0;
            r_mem_x_rd_vld <= 1'b0;
            r_mem_x_rd     <= 32'd0;
            r_mem_rd_idx   <= 5'd0;
`ifdef MEM_MISALIGN_CHK_EN
            r_misalign     <= 1'b0;
`endif
        end else begin
            r_mem_x_rd_vld <= 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
            r_misalign     <= 1'b0;
`endif
            if (r_state == ST_IDLE) begin
                if (w_accept) begin
                    // Low address bits are cleared so the bus only ever sees word addresses.
                    r_dmem_req   <= 1'b1;
                    r_dmem_we    <= !w_is_read;
                    r_dmem_addr  <= EX_MEMaddr & 32'hFFFF_FFFC;
                    r_dmem_be    <= w_is_read ? 4'hF : EX_MEMwren;
                    r_dmem_wdata <= EX_MEMwrdata;
                    r_ld_idx     <= EX_rd_idx;
`ifdef MEM_MISALIGN_CHK_EN
                end else if (w_mem_op) begin
                    r_misalign <= 1'b1;
`endif
                end else if (!w_mem_op && EX_x_rd_vld) begin
                    r_mem_x_rd_vld <= 1'b1;
                    r_mem_x_rd     <= EX_x_rd;
                    r_mem_rd_idx   <= EX_rd_idx;
                end
            end else if (dmem_ack) begin
                r_dmem_req <= 1'b0;
                if (!r_dmem_we) begin
                    r_mem_x_rd_vld <= 1'b1;
                    r_mem_x_rd     <= dmem_rdata;
                    r_mem_rd_idx   <= r_ld_idx;
                end
            end
        end
    end

    assign dmem_req     = r_dmem_req;
    assign dmem_we      = r_dmem_we;
    assign dmem_addr    = r_dmem_addr;
    assign dmem_be      = r_dmem_be;
    assign dmem_wdata   = r_dmem_wdata;
    assign MEM_x_rd_vld = r_mem_x_rd_vld;
    assign MEM_x_rd     = r_mem_x_rd;
    assign MEM_rd_idx   = r_mem_rd_idx;

endmodule
